// File: rtl/wb_port_ctrl_pkg.sv
// Shared types and widths for the write-back port controller.
package arm_wb_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] dest;
  } load_tag_t;

endpackage

// File: rtl/wb_port_ctrl_if.sv
// MEM/WB retire handshake, data-memory response and register-file write port.
interface wb_port_ctrl_if;
  import arm_wb_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_wb_en;
  logic                  in_mem_r_en;
  logic [REG_ADDR_W-1:0] in_dest;
  logic [DATA_W-1:0]     in_alu_result;
  logic                  mem_rsp_valid;
  logic [DATA_W-1:0]     mem_rsp_data;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  pend_valid;
  logic [REG_ADDR_W-1:0] pend_dest;

  modport master (
    output in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_result,
    output mem_rsp_valid, mem_rsp_data,
    input  in_ready, rf_we, rf_waddr, rf_wdata, pend_valid, pend_dest
  );

  modport slave (
    input  in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_result,
    input  mem_rsp_valid, mem_rsp_data,
    output in_ready, rf_we, rf_waddr, rf_wdata, pend_valid, pend_dest
  );

endinterface

// File: rtl/wb_port_ctrl_wait_counter.sv
// Load wait counter: cleared on load accept, counts WAIT_MEM cycles,
// tc flags the cycle in which the count reaches TIMEOUT_CYCLES.
module wb_wait_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds completed wait cycles, so the current cycle is number cnt+1
  assign tc = inc && (cnt == LAST);

endmodule

// File: rtl/wb_port_ctrl.sv
// Single register-file write port controller: ALU results retire directly,
// loads freeze the pipeline until the data memory responds or times out.
//
// state    | meaning
// S_IDLE   | accepting retiring instructions, in_ready high
// S_WAIT   | load outstanding, pipeline frozen until response or timeout
module wb_port_ctrl
  import arm_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_port_ctrl_if.slave    bus,
  output logic             err_timeout,
  output logic             err_spurious,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]            state;
  load_tag_t             tag;
  logic                  xfer;
  logic                  wait_clr;
  logic                  wait_inc;
  logic                  wait_tc;
  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0]     rf_wdata_q;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.pend_valid = (state == S_WAIT) && tag.wb_en;
  assign bus.pend_dest  = tag.dest;

  assign xfer     = bus.in_valid && (state == S_IDLE);
  assign wait_clr = xfer && bus.in_mem_r_en;
  assign wait_inc = (state == S_WAIT);

  wb_wait_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (wait_clr),
    .inc  (wait_inc),
    .tc   (wait_tc)
  );

  always_comb begin
    wb_addr = bus.in_dest;
    wb_data = bus.in_alu_result;
    if (state == S_WAIT) begin
      wb_addr = tag.dest;
      wb_data = bus.mem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      tag          <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      rf_we_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.mem_rsp_valid) begin
            err_spurious <= 1'b1;
          end
          if (xfer) begin
            if (bus.in_mem_r_en) begin
              tag.wb_en <= bus.in_wb_en;
              tag.dest  <= bus.in_dest;
              state     <= S_WAIT;
            end else begin
              rf_we_q    <= bus.in_wb_en;
              rf_waddr_q <= wb_addr;
              rf_wdata_q <= wb_data;
            end
          end
        end
        S_WAIT: begin
          if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
          // a response in the terminal cycle still completes the load
          if (bus.mem_rsp_valid) begin
            rf_we_q    <= tag.wb_en;
            rf_waddr_q <= wb_addr;
            rf_wdata_q <= wb_data;
            state      <= S_IDLE;
          end else if (wait_tc) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_port_ctrl.md
# wb_port_ctrl

Write-back port controller for the ARM pipeline's single register-file write port. It accepts one retiring instruction per cycle from the MEM/WB boundary. ALU results are written back directly; for loads it freezes the pipeline until the variable-latency data memory responds. It also exports the in-flight load destination to the hazard unit and keeps error and stall statistics.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, maximum WAIT_MEM cycles before a load is abandoned (≥1)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  instruction retiring at MEM/WB
- in_ready  out  1  controller can accept; low = pipeline freeze
- in_wb_en  in  1  instruction writes a register
- in_mem_r_en  in  1  instruction is a load (result comes from memory)
- in_dest  in  4  destination register
- in_alu_result  in  32  ALU result
- mem_rsp_valid  in  1  load data valid (single-cycle pulse)
- mem_rsp_data  in  32  load data
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  4  write address (registered)
- rf_wdata  out  32  write data (registered)
- pend_valid  out  1  load with wb_en outstanding
- pend_dest  out  4  its destination
- err_timeout  out  1  sticky: a load timed out
- err_spurious  out  1  sticky: mem_rsp_valid outside WAIT_MEM
- stall_cnt  out  CNT_W  saturating count of WAIT_MEM cycles

## Operation
- States: IDLE, WAIT_MEM.
- in_ready = (state == IDLE). A transfer happens when in_valid && in_ready.
- IDLE, transfer, !in_mem_r_en:
  - Next cycle: rf_we = in_wb_en, rf_waddr = in_dest, rf_wdata = in_alu_result.
  - State stays IDLE.
- IDLE, transfer, in_mem_r_en:
  - Latch in_dest and in_wb_en; clear the wait counter.
  - Go to WAIT_MEM. rf_we = 0 next cycle.
- WAIT_MEM:
  - The wait counter increments each cycle.
  - stall_cnt increments each cycle, saturating at all-ones.
  - On mem_rsp_valid: next cycle rf_we = latched wb_en, rf_waddr = latched dest, rf_wdata = mem_rsp_data. Go to IDLE.
  - Else, if the wait counter reaches TIMEOUT_CYCLES: go to IDLE, rf_we = 0, set err_timeout.
  - If mem_rsp_valid and timeout occur in the same cycle, the response wins and no error is flagged.
- IDLE, mem_rsp_valid: data discarded, err_spurious set, no write.
- No transfer: rf_we = 0 next cycle. rf_waddr and rf_wdata hold their last values.
- pend_valid = (state == WAIT_MEM) && latched wb_en. pend_dest = latched dest.
- A load with in_wb_en = 0 still waits for its response, but produces no write.

## Timing
- Reset (rst_n low at a clk edge):
  - state = IDLE, rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - pend_valid = 0, pend_dest = 0.
  - err_timeout = 0, err_spurious = 0, stall_cnt = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-WAIT_MEM aborts the load; no write is issued. A response arriving after reset is treated as spurious.
- ALU write-back latency: 1 cycle from transfer to rf_we.
- Load write-back latency: 1 cycle after mem_rsp_valid. in_ready returns high in that same cycle, so back-to-back load → ALU retires with no bubble beyond the memory wait.
- Minimum load occupancy: response in the cycle after the transfer gives 1 WAIT_MEM cycle.
- Timeout: a load accepted at cycle t with no response returns to IDLE at cycle t+TIMEOUT_CYCLES+1.
- in_ready depends only on registered state; there is no combinational path from any input.

## Structure
- Package arm_wb_pkg:
  - state enum {IDLE, WAIT_MEM}
  - REG_ADDR_W = 4, DATA_W = 32
- One sub-module, wb_wait_counter: clear / increment / terminal-count compare against TIMEOUT_CYCLES. It is instantiated for the timeout.
- stall_cnt is inline saturating logic.
- The data-select mux is internal; no separate mux instance is needed.

## Test plan
- ALU op: in_valid, wb_en=1, dest=3, alu=0x0000_1234 → next cycle rf_we=1, waddr=3, wdata=0x1234; in_ready stays 1.
- Load, dest=5, response 0xDEAD_BEEF after 4 cycles → in_ready low for 4 cycles, pend_valid=1 with pend_dest=5, stall_cnt=4, then rf_we=1, wdata=0xDEADBEEF. An ALU op held on in_valid is accepted in the response-write cycle.
- TIMEOUT_CYCLES=8, load with no response → IDLE after 8 wait cycles, err_timeout=1, rf_we never asserted.
- Response coincident with the timeout cycle → write performed, err_timeout stays 0.
- mem_rsp_valid pulse in IDLE → err_spurious=1, rf_we=0. rst_n low during WAIT_MEM → all outputs at reset values next cycle, in_ready=1.
- CNT_W=4, loads totalling 20 wait cycles → stall_cnt saturates at 15.
